// File: rtl/vedic_mult_seq_ctrl.sv
// Sequencer driving one shared HALF x HALF multiplier through four partial
// products and accumulating them into a 2*WIDTH-bit result.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid/in_ready     operand handshake (a, b)
//   mul_a/mul_b/mul_p     shared combinational multiplier
//   out_valid/out_ready   result handshake (product)
//   busy                  high whenever not idle
module vedic_mult_seq_ctrl #(
  parameter  int WIDTH = 32,
  localparam int HALF  = WIDTH / 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [HALF-1:0]    mul_a,
  output logic [HALF-1:0]    mul_b,
  input  logic [WIDTH-1:0]   mul_p,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PP0  = 3'd1,
    PP1  = 3'd2,
    PP2  = 3'd3,
    PP3  = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic                 out_valid_q, out_valid_d;

  logic [HALF-1:0]      a_lo, a_hi, b_lo, b_hi;
  logic [2*WIDTH-1:0]   pp_ext;
  logic [2*WIDTH-1:0]   term;

  assign a_lo   = a_q[HALF-1:0];
  assign a_hi   = a_q[WIDTH-1:HALF];
  assign b_lo   = b_q[HALF-1:0];
  assign b_hi   = b_q[WIDTH-1:HALF];
  assign pp_ext = {{WIDTH{1'b0}}, mul_p};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    mul_a       = '0;
    mul_b       = '0;
    term        = '0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          acc_d   = '0;
          state_d = PP0;
        end
      end
      PP0: begin
        mul_a   = a_lo;
        mul_b   = b_lo;
        term    = pp_ext;
        acc_d   = acc_q + term;
        state_d = PP1;
      end
      PP1: begin
        mul_a   = a_lo;
        mul_b   = b_hi;
        term    = pp_ext << HALF;
        acc_d   = acc_q + term;
        state_d = PP2;
      end
      PP2: begin
        mul_a   = a_hi;
        mul_b   = b_lo;
        term    = pp_ext << HALF;
        acc_d   = acc_q + term;
        state_d = PP3;
      end
      PP3: begin
        mul_a       = a_hi;
        mul_b       = b_hi;
        term        = pp_ext << WIDTH;
        acc_d       = acc_q + term;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign product   = acc_q;

endmodule
